// File: rtl/alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | alu_seq : registered ALU with start/done handshake and optional iterative    |
// |           MUL/DIVU (compiled in when ALU_MULDIV_EN is defined).              |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic             overflow
);

   localparam logic [3:0] c_OP_AND  = 4'b0000;
   localparam logic [3:0] c_OP_OR   = 4'b0001;
   localparam logic [3:0] c_OP_ADD  = 4'b0010;
   localparam logic [3:0] c_OP_SLTU = 4'b0011;
   localparam logic [3:0] c_OP_SUB  = 4'b0110;
   localparam logic [3:0] c_OP_SLT  = 4'b0111;
   localparam logic [3:0] c_OP_SLL  = 4'b1000;
   localparam logic [3:0] c_OP_SRL  = 4'b1001;
   localparam logic [3:0] c_OP_SRA  = 4'b1010;
   localparam logic [3:0] c_OP_NOR  = 4'b1100;

`ifdef ALU_MULDIV_EN
   localparam logic [3:0] c_OP_MUL  = 4'b1110;
   localparam logic [3:0] c_OP_DIVU = 4'b1111;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FIN = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIN = 2'd2} state_t;
`endif

   state_t           r_state, w_state_next;
   logic             w_accept, w_is_iter, w_last;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_sum, w_diff, w_res, w_iter_res;
   logic             w_ovf;

   assign done     = (r_state == S_FIN);
   assign w_accept = start && !busy;
   assign w_shamt  = inB[SHW-1:0];
   assign w_sum    = inA + inB;
   assign w_diff   = inA - inB;

   // Single-cycle datapath; MUL/DIVU opcodes fall through to pass-inA here.
   always_comb begin
      w_res = inA;
      w_ovf = 1'b0;
      case (control)
         c_OP_AND:  w_res = inA & inB;
         c_OP_OR:   w_res = inA | inB;
         c_OP_NOR:  w_res = ~(inA | inB);
         c_OP_ADD: begin
            w_res = w_sum;
            w_ovf = (inA[WIDTH-1] == inB[WIDTH-1]) && (w_sum[WIDTH-1] != inA[WIDTH-1]);
         end
         c_OP_SUB: begin
            w_res = w_diff;
            w_ovf = (inA[WIDTH-1] != inB[WIDTH-1]) && (w_diff[WIDTH-1] != inA[WIDTH-1]);
         end
         c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(inA) < $signed(inB))};
         c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (inA < inB)};
         c_OP_SLL:  w_res = inA << w_shamt;
         c_OP_SRL:  w_res = inA >> w_shamt;
         c_OP_SRA:  w_res = $unsigned($signed(inA) >>> w_shamt);
         default:   w_res = inA;
      endcase
   end

`ifdef ALU_MULDIV_EN
   // r_acc: product (MUL) or partial remainder (DIVU); r_opa: multiplicand or
   // dividend shifting out / quotient shifting in; r_opb: multiplier or divisor.
   logic [WIDTH:0]   r_acc, w_acc_nxt, w_shift_rem, w_trial;
   logic [WIDTH-1:0] r_opa, r_opb, w_opa_nxt, w_opb_nxt;
   logic [SHW-1:0]   r_cnt;
   logic             r_is_div;

   assign busy        = (r_state == S_ITER);
   assign w_is_iter   = (control == c_OP_MUL) || (control == c_OP_DIVU);
   assign w_last      = (r_cnt == SHW'(WIDTH - 1));
   assign w_shift_rem = {r_acc[WIDTH-1:0], r_opa[WIDTH-1]};
   assign w_trial     = w_shift_rem - {1'b0, r_opb};

   always_comb begin
      w_acc_nxt = r_acc;
      w_opa_nxt = r_opa;
      w_opb_nxt = r_opb;
      if (r_is_div) begin
         // A zero divisor never yields a negative trial, so the quotient fills with ones.
         if (!w_trial[WIDTH]) begin
            w_acc_nxt = w_trial;
            w_opa_nxt = {r_opa[WIDTH-2:0], 1'b1};
         end else begin
            w_acc_nxt = w_shift_rem;
            w_opa_nxt = {r_opa[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (r_opb[0]) w_acc_nxt = r_acc + {1'b0, r_opa};
         w_opa_nxt = r_opa << 1;
         w_opb_nxt = r_opb >> 1;
      end
   end

   assign w_iter_res = r_is_div ? w_opa_nxt : w_acc_nxt[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
      end else if (w_accept && w_is_iter) begin
         r_acc    <= '0;
         r_opa    <= inA;
         r_opb    <= inB;
         r_cnt    <= '0;
         r_is_div <= (control == c_OP_DIVU);
      end else if (r_state == S_ITER) begin
         r_acc    <= w_acc_nxt;
         r_opa    <= w_opa_nxt;
         r_opb    <= w_opb_nxt;
         r_cnt    <= r_cnt + 1'b1;
      end
   end
`else
   assign busy       = 1'b0;
   assign w_is_iter  = 1'b0;
   assign w_last     = 1'b0;
   assign w_iter_res = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
`ifdef ALU_MULDIV_EN
         S_ITER: if (w_last) w_state_next = S_FIN;
`endif
         S_IDLE, S_FIN: begin
            w_state_next = S_IDLE;
            if (w_accept) w_state_next = w_is_iter ? state_t'(2'd1) : S_FIN;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Visible results only ever update on the edge that makes done rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out  <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
      end else if (w_accept && !w_is_iter) begin
         alu_out  <= w_res;
         zero     <= (w_res == '0);
         overflow <= w_ovf;
      end else if (busy && w_last) begin
         alu_out  <= w_iter_res;
         zero     <= (w_iter_res == '0);
         overflow <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_alu_seq : randomized self-checking bench for alu_seq against an           |
// |              arithmetic reference model (follows ALU_MULDIV_EN).             |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module tb_alu_seq;
   localparam int WIDTH = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [3:0]        control = '0;
   logic [WIDTH-1:0]  inA = '0, inB = '0;
   logic              busy, done, zero, overflow;
   logic [WIDTH-1:0]  alu_out;
   int                n_checks = 0;
   int                n_errors = 0;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .control(control),
      .inA(inA), .inB(inB), .busy(busy), .done(done),
      .alu_out(alu_out), .zero(zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit is_iter(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
      return (op == 4'b1110) || (op == 4'b1111);
`else
      return 1'b0;
`endif
   endfunction

   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic o);
      longint     sa, sb, t;
      logic [63:0] p;
      int         sh;
      sa = $signed(a);
      sb = $signed(b);
      sh = int'(b[4:0]);
      r  = a;
      o  = 1'b0;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b1100: r = ~(a | b);
         4'b0010: begin t = sa + sb; r = t[31:0]; o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         4'b0110: begin t = sa - sb; r = t[31:0]; o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
         4'b0011: r = (a < b) ? 32'd1 : 32'd0;
         4'b1000: r = a << sh;
         4'b1001: r = a >> sh;
         4'b1010: begin t = sa >>> sh; r = t[31:0]; end
`ifdef ALU_MULDIV_EN
         4'b1110: begin p = 64'(a) * 64'(b); r = p[31:0]; end
         4'b1111: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
`endif
         default: r = a;
      endcase
   endfunction

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; control = op; inA = a; inB = b;
   endtask

   // Called just after the accepting edge; returns at the negedge where done is seen.
   task automatic finish_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er;
      logic        eo;
      int          lat, exp_lat;
      bit          busy_ok;
      model(op, a, b, er, eo);
      exp_lat = is_iter(op) ? WIDTH + 1 : 1;
      #1;
      start = 1'b0; control = 4'($urandom); inA = $urandom; inB = $urandom;
      lat = 0;
      busy_ok = 1'b1;
      forever begin
         @(negedge clk);
         lat++;
         if (done) break;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (lat == 3) begin start = 1'b1; control = 4'b0000; end
         if (lat == 4) start = 1'b0;
         if (lat > 3 * WIDTH) begin
            check({tag, "_timeout"}, 64'(lat), 64'(exp_lat));
            return;
         end
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_res"}, alu_out, er);
      check({tag, "_zero"}, zero, (er == 0));
      check({tag, "_ovf"}, overflow, eo);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      if (exp_lat > 1) check({tag, "_busy_during"}, busy_ok, 1'b1);
   endtask

   task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      check({tag, "_idle_done"}, done, 1'b0);
      drive(op, a, b);
      @(posedge clk);
      finish_op(tag, op, a, b);
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corners [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
      return $urandom;
   endfunction

   initial begin
      logic [31:0] a, b, er;
      logic [3:0]  op;
      logic        eo;
      bit          seen;

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_out", alu_out, 32'h0);
      check("rst_zero", zero, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      rst_n = 1'b1;

      issue("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1);
      check("add_ovf_const", alu_out, 32'h8000_0000);
      issue("sub_zero", 4'b0110, 32'd5, 32'd5);
      check("sub_zero_const", zero, 1'b1);
      issue("slt", 4'b0111, 32'hFFFF_FFFF, 32'h1);
      issue("sltu", 4'b0011, 32'hFFFF_FFFF, 32'h1);
      issue("sra", 4'b1010, 32'h8000_0000, 32'h24);
      check("sra_const", alu_out, 32'hF800_0000);
      issue("srl", 4'b1001, 32'h8000_0000, 32'h24);
      issue("sll", 4'b1000, 32'h1, 32'd31);
      issue("nor", 4'b1100, 32'h0F0F_0000, 32'h0000_00FF);
      issue("pass", 4'b0100, 32'hDEAD_BEEF, 32'h1234);
      issue("mul", 4'b1110, 32'h0001_0000, 32'h0001_0001);
`ifdef ALU_MULDIV_EN
      check("mul_const", alu_out, 32'h0001_0000);
`endif
      issue("divu", 4'b1111, 32'd100, 32'd7);
      drive(4'b1111, 32'h1234_5678, 32'h0);
      @(posedge clk);
      finish_op("divu0_b2b", 4'b1111, 32'h1234_5678, 32'h0);

      // Mid-run asynchronous reset, checked between clock edges.
      issue("pre_rst", 4'b0001, 32'h00F0, 32'h0F00);
      @(negedge clk);
      drive(4'b1110, 32'h0003_0005, 32'h0007_0009);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_busy", busy, 1'b0);
      check("async_done", done, 1'b0);
      check("async_out", alu_out, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("no_done_after_rst", seen, 1'b0);
      issue("post_rst", 4'b0010, 32'd1000, 32'd234);

      // Start held high: one result per cycle, in issue order.
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         do op = 4'($urandom); while (is_iter(op));
         a = pick_operand();
         b = pick_operand();
         model(op, a, b, er, eo);
         drive(op, a, b);
         @(negedge clk);
         check("b2b_done", done, 1'b1);
         check("b2b_res", alu_out, er);
         check("b2b_ovf", overflow, eo);
      end
      start = 1'b0;

      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom);
         a  = pick_operand();
         b  = pick_operand();
         if (op == 4'b1111 && $urandom_range(3) != 0) b = 32'($urandom_range(1000, 1));
         issue("rand", op, a, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
